mont_mul_cios: RTL and testbench

- Parametrised word-serial Montgomery multiplier for the RSA decryption datapath, using the CIOS method: computes A*B*R^-1 mod N with R = 2^(W*NW).
- Operands stream in least-significant word first, and the result streams out the same way over valid/ready handshakes.
- Generalises the fixed 32x32-bit MonPro operand path to any word width and word count, and adds backpressure, a busy flag and the final conditional subtraction.
- The exponentiation controller instantiates this block for all squarings and multiplies.

---
 rtl/mont_pkg.sv | 23 ++
 rtl/mont_mac.sv | 16 +
 rtl/mont_mul_cios.sv | 196 +++++++++++++++++++
 tb/tb_mont_mul_cios.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Types and constants shared by the CIOS Montgomery multiplier and the
// exponentiation controller that drives it.
package mont_pkg;
    localparam int MONT_W  = 32;
    localparam int MONT_NW = 32;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_LOAD  = 4'd1,
        ST_MUL   = 4'd2,
        ST_MUL_C = 4'd3,
        ST_RED_M = 4'd4,
        ST_RED   = 4'd5,
        ST_RED_C = 4'd6,
        ST_SUB   = 4'd7,
        ST_OUT   = 4'd8
    } mont_state_e;

    // Cycles from the last load handshake to the first out_valid.
    function automatic int lat(input int nw);
        return nw * (2 * nw + 3) + nw;
    endfunction
endpackage

// File: rtl/mont_mac.sv
// Combinational W x W multiply with two W-bit addends; the result
// {carry, sum} always fits in 2W bits.
module mont_mac #(
    parameter int W = 32
) (
    input  logic [W-1:0]   x_i,
    input  logic [W-1:0]   y_i,
    input  logic [W-1:0]   z_i,
    input  logic [W-1:0]   c_i,
    output logic [2*W-1:0] r_o
);
    logic [2*W-1:0] prod;

    assign prod = {{W{1'b0}}, y_i} * {{W{1'b0}}, z_i};
    assign r_o  = prod + {{W{1'b0}}, x_i} + {{W{1'b0}}, c_i};
endmodule

// File: rtl/mont_mul_cios.sv
// Word-serial CIOS Montgomery multiplier: A*B*2^-(W*NW) mod N, operands and
// result streamed LSW first over valid/ready, one shared multiply-add.
module mont_mul_cios
    import mont_pkg::*;
#(
    parameter int W  = MONT_W,
    parameter int NW = MONT_NW,
    parameter int CW = $clog2(NW + 2)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_word,
    input  logic [W-1:0] b_word,
    input  logic [W-1:0] n_word,
    input  logic [W-1:0] n0_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res_out,
    output logic         busy,
    output logic [3:0]   state
);
    localparam int            AW   = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CW-1:0] LAST = CW'(NW - 1);

    mont_state_e   state_q;
    logic [CW-1:0] i_q, j_q;
    logic [W-1:0]  c_q, m_q, n0inv_q, t_nw_q, t_hi_q;
    logic          borrow_q, sel_d_q, in_ready_q, out_valid_q, busy_q;

    logic [W-1:0]  a_q [NW];
    logic [W-1:0]  b_q [NW];
    logic [W-1:0]  n_q [NW];
    logic [W-1:0]  d_q [NW];
    logic [W-1:0]  t_q [NW];

    logic [AW-1:0]  jx, ix;
    logic [W-1:0]   t_rd, mac_x, mac_y, mac_z, mac_c, mac_sum, mac_cy;
    logic [2*W-1:0] mac_r;
    logic [W:0]     diff;
    logic           load_hs;

    assign jx      = j_q[AW-1:0];
    assign ix      = i_q[AW-1:0];
    assign load_hs = in_valid && (state_q == ST_IDLE || state_q == ST_LOAD);
    // The first outer pass sees t as all-zero without spending cycles clearing it.
    assign t_rd    = (state_q == ST_MUL && i_q == '0) ? '0 : t_q[jx];
    assign diff    = {1'b0, t_rd} - {1'b0, n_q[jx]} - {{W{1'b0}}, borrow_q};
    assign mac_sum = mac_r[W-1:0];
    assign mac_cy  = mac_r[2*W-1:W];

    always_comb begin
        mac_x = t_rd;
        mac_y = '0;
        mac_z = '0;
        mac_c = '0;
        case (state_q)
            ST_MUL:   begin mac_y = a_q[jx]; mac_z = b_q[ix]; mac_c = c_q; end
            ST_MUL_C: begin mac_x = t_nw_q; mac_c = c_q; end
            ST_RED_M: begin mac_x = '0; mac_y = t_rd; mac_z = n0inv_q; end
            ST_RED:   begin mac_y = m_q; mac_z = n_q[jx]; mac_c = c_q; end
            ST_RED_C: begin mac_x = t_nw_q; mac_c = c_q; end
            default:  ;
        endcase
    end

    mont_mac #(.W(W)) u_mac (
        .x_i (mac_x),
        .y_i (mac_y),
        .z_i (mac_z),
        .c_i (mac_c),
        .r_o (mac_r)
    );

    always_ff @(posedge clk) begin
        if (load_hs) begin
            a_q[jx] <= a_word;
            b_q[jx] <= b_word;
            n_q[jx] <= n_word;
        end
        if (state_q == ST_SUB) d_q[jx] <= diff[W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            i_q         <= '0;
            j_q         <= '0;
            c_q         <= '0;
            m_q         <= '0;
            n0inv_q     <= '0;
            t_nw_q      <= '0;
            t_hi_q      <= '0;
            borrow_q    <= 1'b0;
            sel_d_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < NW; k++) t_q[k] <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_LOAD: if (in_valid) begin
                    if (state_q == ST_IDLE) begin
                        n0inv_q <= n0_inv;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                    if (j_q == LAST) begin
                        state_q    <= ST_MUL;
                        i_q        <= '0;
                        j_q        <= '0;
                        c_q        <= '0;
                        t_nw_q     <= '0;
                        t_hi_q     <= '0;
                        in_ready_q <= 1'b0;
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                end
                ST_MUL: begin
                    t_q[jx] <= mac_sum;
                    c_q     <= mac_cy;
                    if (j_q == LAST) begin
                        j_q     <= '0;
                        state_q <= ST_MUL_C;
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                end
                ST_MUL_C: begin
                    t_nw_q  <= mac_sum;
                    t_hi_q  <= mac_cy;
                    state_q <= ST_RED_M;
                end
                ST_RED_M: begin
                    m_q     <= mac_sum;
                    c_q     <= '0;
                    state_q <= ST_RED;
                end
                ST_RED: begin
                    c_q <= mac_cy;
                    // Word j=0 is zero by construction of m; each later word shifts down one slot.
                    if (j_q != '0) t_q[jx - AW'(1)] <= mac_sum;
                    if (j_q == LAST) begin
                        j_q     <= '0;
                        state_q <= ST_RED_C;
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                end
                ST_RED_C: begin
                    t_q[AW'(NW - 1)] <= mac_sum;
                    t_nw_q           <= t_hi_q + mac_cy;
                    c_q              <= '0;
                    if (i_q == LAST) begin
                        state_q  <= ST_SUB;
                        borrow_q <= 1'b0;
                    end else begin
                        i_q     <= i_q + CW'(1);
                        state_q <= ST_MUL;
                    end
                end
                ST_SUB: begin
                    borrow_q <= diff[W];
                    if (j_q == LAST) begin
                        sel_d_q     <= (t_nw_q == W'(1)) || !diff[W];
                        j_q         <= '0;
                        state_q     <= ST_OUT;
                        out_valid_q <= 1'b1;
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                end
                ST_OUT: if (out_ready) begin
                    if (j_q == LAST) begin
                        j_q         <= '0;
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign state     = state_q;
    assign res_out   = out_valid_q ? (sel_d_q ? d_q[jx] : t_q[jx]) : '0;
endmodule

// File: tb/tb_mont_mul_cios.sv
// Bench for mont_mul_cios: directed runs on a W=8/NW=2 instance and random
// 1024-bit runs on the default instance against a bit-serial Montgomery model.
`timescale 1ns/1ps
module tb_mont_mul_cios;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [7:0] s_a, s_b, s_n, s_n0, s_res;
    logic [3:0] s_state;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [31:0] b_a, b_b, b_n, b_n0, b_res;
    logic [3:0]  b_state;

    mont_mul_cios #(.W(8), .NW(2)) u_small (
        .clk(clk), .reset(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a_word(s_a), .b_word(s_b), .n_word(s_n), .n0_inv(s_n0),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .res_out(s_res),
        .busy(s_busy), .state(s_state)
    );

    mont_mul_cios #(.W(32), .NW(32)) u_big (
        .clk(clk), .reset(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .a_word(b_a), .b_word(b_b), .n_word(b_n), .n0_inv(b_n0),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .res_out(b_res),
        .busy(b_busy), .state(b_state)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] n_small = 16'hFFF1;
    int small_lat = 2 * (2 * 2 + 3) + 2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // A*B*2^-bits mod N by repeated halving modulo N.
    function automatic logic [1023:0] mont_ref(input logic [1023:0] a, b, n, input int bits);
        logic [2047:0] x;
        x = {1024'b0, a} * {1024'b0, b};
        for (int k = 0; k < bits; k++) begin
            if (x[0]) x = x + {1024'b0, n};
            x = x >> 1;
        end
        if (x >= {1024'b0, n}) x = x - {1024'b0, n};
        return x[1023:0];
    endfunction

    function automatic logic [1023:0] rnd1024();
        logic [1023:0] r;
        for (int w = 0; w < 32; w++) r[32*w +: 32] = $urandom;
        return r;
    endfunction

    task automatic s_load(input logic [15:0] a, b);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            s_in_valid = 1'b1;
            s_a = a[8*k +: 8];
            s_b = b[8*k +: 8];
            s_n = n_small[8*k +: 8];
            s_n0 = 8'hEF;
            @(posedge clk);
        end
        #1 s_in_valid = 1'b0;
    endtask

    task automatic s_run(input logic [15:0] a, b, input int stall, input logic [7:0] stall_exp,
                         output logic [15:0] res, output int lat_c);
        s_load(a, b);
        lat_c = 0;
        do begin
            @(posedge clk);
            lat_c++;
            #1;
        end while (!s_out_valid && lat_c < 200);
        chk("s_outv_rise", s_out_valid, 1);
        repeat (stall) begin
            @(negedge clk);
            chk("s_stall_res", s_res, stall_exp);
            chk("s_stall_busy", s_busy, 1);
            chk("s_stall_vld", s_out_valid, 1);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("s_outv_word", s_out_valid, 1);
            res[8*k +: 8] = s_res;
            s_out_ready = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        s_out_ready = 1'b0;
        chk("s_done_vld", s_out_valid, 0);
        chk("s_done_busy", s_busy, 0);
        chk("s_done_rdy", s_in_ready, 1);
    endtask

    task automatic b_op(input logic [1023:0] a, b, n, input logic [31:0] n0,
                        output logic [1023:0] res);
        int idx, cyc;
        for (int k = 0; k < 32; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                b_in_valid = 1'b0;
                b_a = $urandom; b_b = $urandom; b_n = $urandom; b_n0 = $urandom;
            end
            @(negedge clk);
            b_in_valid = 1'b1;
            b_a = a[32*k +: 32];
            b_b = b[32*k +: 32];
            b_n = n[32*k +: 32];
            b_n0 = (k == 0) ? n0 : $urandom;
            @(posedge clk);
        end
        #1 b_in_valid = 1'b0;
        res = '0;
        idx = 0;
        cyc = 0;
        while (idx < 32 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            b_out_ready = ($urandom_range(0, 3) != 0);
            if (b_out_valid && b_out_ready) begin
                res[32*idx +: 32] = b_res;
                idx++;
            end
            @(posedge clk);
        end
        #1 b_out_ready = 1'b0;
        chk("b_words", idx, 32);
    endtask

    initial begin
        logic [15:0]   sres;
        int            lc;
        logic [1023:0] n, a, b, got, exp;
        logic [31:0]   inv;

        rst = 1'b1;
        s_in_valid = 0; s_out_ready = 0; s_a = 0; s_b = 0; s_n = 0; s_n0 = 0;
        b_in_valid = 0; b_out_ready = 0; b_a = 0; b_b = 0; b_n = 0; b_n0 = 0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", s_in_ready, 1);
        chk("rst_out_valid", s_out_valid, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_res", s_res, 0);
        chk("rst_big_ready", b_in_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        s_run(16'h0001, 16'h000F, 0, 8'h00, sres, lc);
        chk("t1_res", sres, 16'h0001);
        chk("t1_latency", lc, small_lat);
        s_run(16'h000F, 16'h000F, 0, 8'h00, sres, lc);
        chk("t2_res_a", sres, 16'h000F);
        s_run(16'h0000, 16'h1234, 0, 8'h00, sres, lc);
        chk("t2_res_b", sres, 16'h0000);
        s_run(16'hFFF0, 16'hFFF0, 5, 8'hE1, sres, lc);
        chk("t3_res", sres, 16'hEEE1);

        // Reset in the middle of the second reduction pass.
        s_load(16'h0001, 16'h000F);
        repeat (11) @(posedge clk);
        #2;
        chk("t4_midop_rdy", s_in_ready, 0);
        chk("t4_midop_busy", s_busy, 1);
        rst = 1'b1;
        #1;
        chk("t4_rst_rdy", s_in_ready, 1);
        chk("t4_rst_vld", s_out_valid, 0);
        chk("t4_rst_busy", s_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        s_run(16'h0001, 16'h000F, 0, 8'h00, sres, lc);
        chk("t4_after_res", sres, 16'h0001);

        for (int t = 0; t < 20; t++) begin
            n = rnd1024();
            n[0] = 1'b1;
            if (t[0]) n[1023] = 1'b1;
            a = rnd1024() % n;
            b = rnd1024() % n;
            inv = n[31:0];
            repeat (5) inv = inv * (32'd2 - n[31:0] * inv);
            inv = -inv;
            b_op(a, b, n, inv, got);
            exp = mont_ref(a, b, n, 1024);
            for (int w = 0; w < 32; w++)
                chk($sformatf("t5_op%0d_w%0d", t, w), got[32*w +: 32], exp[32*w +: 32]);
            chk("t5_busy_low", b_busy, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
